// File: rtl/beat_pkg.sv
// beat_pkg: shared types and constants for the beat controller.
//   beat_state_t - controller FSM states (IDLE, ARMED, HOLDOFF)
//   THRESH_MAX   - highest detector threshold code
//   FFT_INDEX_W  - width of the FFT bin index
//   adapt_code() - one adaptation step of the threshold code
package beat_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } beat_state_t;

    localparam logic [3:0] THRESH_MAX  = 4'd15;
    localparam int         FFT_INDEX_W = 7;

    // Too many beats -> stricter code, too few -> more sensitive code.
    // Saturates at 0 and THRESH_MAX; never wraps.
    function automatic logic [3:0] adapt_code(
        input logic [3:0] code,
        input logic [7:0] count,
        input logic [7:0] rate_min,
        input logic [7:0] rate_max
    );
        if (count > rate_max && code < THRESH_MAX) begin
            return code + 4'd1;
        end else if (count < rate_min && code != 4'd0) begin
            return code - 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: FFT frame-end detection and adaptation-window counter.
//   clk_100mhz, rst  - clock, synchronous active-high reset
//   valid_in         - FFT output beat valid
//   fft_index        - FFT bin index accompanying valid_in
//   run              - window counter advances only while high; clears when low
//   frame_end        - combinational: this cycle carries the last bin of a frame
//   frame_strobe     - registered frame_end (one cycle after the last bin)
//   window_wrap      - combinational: this frame end closes the current window
module frame_tick_gen
    import beat_pkg::*;
#(
    parameter logic [FFT_INDEX_W-1:0] LAST_INDEX    = 7'd127,
    parameter int                     WINDOW_FRAMES = 64
) (
    input  logic                   clk_100mhz,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [FFT_INDEX_W-1:0] fft_index,
    input  logic                   run,
    output logic                   frame_end,
    output logic                   frame_strobe,
    output logic                   window_wrap
);

    localparam int               WIN_W    = (WINDOW_FRAMES > 1) ? $clog2(WINDOW_FRAMES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_FRAMES - 1);

    logic [WIN_W-1:0] win_cnt;

    assign frame_end   = valid_in && (fft_index == LAST_INDEX);
    assign window_wrap = run && frame_end && (win_cnt == WIN_LAST);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            frame_strobe <= 1'b0;
            win_cnt      <= '0;
        end else begin
            frame_strobe <= frame_end;
            if (!run) begin
                win_cnt <= '0;
            end else if (frame_end) begin
                win_cnt <= window_wrap ? '0 : win_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/beat_ctrl.sv
// beat_ctrl: beat hold-off FSM and closed-loop threshold adaptation.
//   clk_100mhz, rst  - clock, synchronous active-high reset
//   enable           - run control; low parks the controller in IDLE
//   valid_in         - FFT output beat valid
//   fft_index        - FFT bin index accompanying valid_in
//   beat_flag_in     - raw beat flag from the detector
//   manual_mode      - 1: beat_threshold follows manual_thresh
//   manual_thresh    - user threshold code
//   beat_threshold   - code driven to the detector (higher = stricter)
//   beat_out         - one-cycle accepted-beat pulse
//   frame_strobe     - one-cycle pulse per completed frame
//   holdoff_active   - high while in HOLDOFF
//   beat_rate        - accepted-beat count of the last completed window
module beat_ctrl
    import beat_pkg::*;
#(
    parameter logic [FFT_INDEX_W-1:0] LAST_INDEX     = 7'd127,
    parameter int                     WINDOW_FRAMES  = 64,
    parameter int                     HOLDOFF_FRAMES = 8,
    parameter int                     RATE_MIN       = 2,
    parameter int                     RATE_MAX       = 8,
    parameter logic [3:0]             INIT_THRESH    = 4'd4
) (
    input  logic                   clk_100mhz,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   valid_in,
    input  logic [FFT_INDEX_W-1:0] fft_index,
    input  logic                   beat_flag_in,
    input  logic                   manual_mode,
    input  logic [3:0]             manual_thresh,
    output logic [3:0]             beat_threshold,
    output logic                   beat_out,
    output logic                   frame_strobe,
    output logic                   holdoff_active,
    output logic [7:0]             beat_rate
);

    localparam int              HO_W       = $clog2(HOLDOFF_FRAMES + 1);
    localparam logic [HO_W-1:0] HO_LOAD    = HO_W'(HOLDOFF_FRAMES);
    localparam logic [7:0]      RATE_MIN_C = 8'(RATE_MIN);
    localparam logic [7:0]      RATE_MAX_C = 8'(RATE_MAX);

    beat_state_t     state;
    logic [HO_W-1:0] holdoff_cnt;
    logic [7:0]      beat_cnt;
    logic [7:0]      beat_cnt_next;
    logic            accept;
    logic            run;
    logic            frame_end;
    logic            window_wrap;

    // Counters only advance while enabled and out of IDLE.
    assign run = enable && (state != IDLE);

    frame_tick_gen #(
        .LAST_INDEX    (LAST_INDEX),
        .WINDOW_FRAMES (WINDOW_FRAMES)
    ) u_frame_tick_gen (
        .clk_100mhz   (clk_100mhz),
        .rst          (rst),
        .valid_in     (valid_in),
        .fft_index    (fft_index),
        .run          (run),
        .frame_end    (frame_end),
        .frame_strobe (frame_strobe),
        .window_wrap  (window_wrap)
    );

    // beat_cnt_next includes a beat accepted this cycle so a wrap in the same
    // cycle reports and adapts on it.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        accept        = 1'b0;
        beat_cnt_next = beat_cnt;
        if (run && state == ARMED && beat_flag_in) begin
            accept = 1'b1;
        end
        if (accept && beat_cnt != 8'hFF) begin
            beat_cnt_next = beat_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state          <= IDLE;
            holdoff_cnt    <= '0;
            beat_cnt       <= '0;
            beat_out       <= 1'b0;
            holdoff_active <= 1'b0;
            beat_rate      <= '0;
            beat_threshold <= INIT_THRESH;
        end else begin
            beat_out <= accept;

            if (manual_mode) begin
                beat_threshold <= manual_thresh;
            end else if (window_wrap) begin
                beat_threshold <= adapt_code(beat_threshold, beat_cnt_next,
                                             RATE_MIN_C, RATE_MAX_C);
            end

            if (window_wrap) begin
                beat_rate <= beat_cnt_next;
            end

            if (!run || window_wrap) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt_next;
            end

            if (!enable) begin
                state          <= IDLE;
                holdoff_cnt    <= '0;
                holdoff_active <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state          <= ARMED;
                        holdoff_cnt    <= '0;
                        holdoff_active <= 1'b0;
                    end
                    ARMED: begin
                        // A coincident frame end is not a decrement: the
                        // count is loaded fresh here.
                        if (beat_flag_in) begin
                            state          <= HOLDOFF;
                            holdoff_cnt    <= HO_LOAD;
                            holdoff_active <= 1'b1;
                        end
                    end
                    HOLDOFF: begin
                        // Release happens on the frame end that finds the
                        // count already at zero, so the hold-off spans
                        // HOLDOFF_FRAMES+1 frame ends.
                        if (frame_end) begin
                            if (holdoff_cnt == '0) begin
                                state          <= ARMED;
                                holdoff_active <= 1'b0;
                            end else begin
                                holdoff_cnt <= holdoff_cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state          <= IDLE;
                        holdoff_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_beat_ctrl.sv
// tb_beat_ctrl: self-checking bench for beat_ctrl.
//   Inputs are driven on the falling edge, outputs sampled on the falling edge
//   (or 1 time unit after the rising edge in the monitors).
//   A second instance with HOLDOFF_FRAMES=4 shares all inputs.
module tb_beat_ctrl;
    import beat_pkg::*;

    logic       clk_100mhz = 1'b0;
    logic       rst;
    logic       enable;
    logic       valid_in;
    logic [6:0] fft_index;
    logic       beat_flag_in;
    logic       manual_mode;
    logic [3:0] manual_thresh;

    logic [3:0] beat_threshold;
    logic       beat_out;
    logic       frame_strobe;
    logic       holdoff_active;
    logic [7:0] beat_rate;

    logic [3:0] h4_threshold;
    logic       h4_beat_out;
    logic       h4_frame_strobe;
    logic       h4_holdoff_active;
    logic [7:0] h4_beat_rate;

    always #5 clk_100mhz = ~clk_100mhz;

    beat_ctrl dut (
        .clk_100mhz     (clk_100mhz),
        .rst            (rst),
        .enable         (enable),
        .valid_in       (valid_in),
        .fft_index      (fft_index),
        .beat_flag_in   (beat_flag_in),
        .manual_mode    (manual_mode),
        .manual_thresh  (manual_thresh),
        .beat_threshold (beat_threshold),
        .beat_out       (beat_out),
        .frame_strobe   (frame_strobe),
        .holdoff_active (holdoff_active),
        .beat_rate      (beat_rate)
    );

    beat_ctrl #(.HOLDOFF_FRAMES(4)) dut_h4 (
        .clk_100mhz     (clk_100mhz),
        .rst            (rst),
        .enable         (enable),
        .valid_in       (valid_in),
        .fft_index      (fft_index),
        .beat_flag_in   (beat_flag_in),
        .manual_mode    (manual_mode),
        .manual_thresh  (manual_thresh),
        .beat_threshold (h4_threshold),
        .beat_out       (h4_beat_out),
        .frame_strobe   (h4_frame_strobe),
        .holdoff_active (h4_holdoff_active),
        .beat_rate      (h4_beat_rate)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int beat_seen   = 0;
    int strobe_seen = 0;
    logic exp_q[$];

    typedef struct {
        logic       manual;
        logic [3:0] mthresh;
        logic       flag;
        logic [7:0] exp_rate;
        logic [3:0] exp_code;
    } win_vec_t;

    win_vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_100mhz);
    endtask

    // One frame from bin `first` up to the last bin, valid every cycle.
    task automatic drive_frame(input int first);
        for (int i = first; i <= 127; i++) begin
            valid_in  = 1'b1;
            fft_index = 7'(i);
            @(negedge clk_100mhz);
        end
        valid_in  = 1'b0;
        fft_index = 7'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; valid_in = 1'b0; fft_index = 7'd0;
        beat_flag_in = 1'b0; manual_mode = 1'b0; manual_thresh = 4'd0;
        cyc(2);
        rst = 1'b0;
    endtask

    // Hold-off must stay high for n_high more short frames, then drop on the next.
    task automatic holdoff_release(input int n_high, input string name);
        for (int k = 0; k < n_high; k++) begin
            drive_frame(124);
            check({name, " holdoff still high"}, holdoff_active, 1);
        end
        drive_frame(124);
        check({name, " holdoff released"}, holdoff_active, 0);
    endtask

    // Frame-strobe scoreboard: expectation pushed from the sampled inputs,
    // popped once the DUT has had its edge.
    always @(posedge clk_100mhz) begin
        logic e;
        exp_q.push_back(!rst && valid_in && fft_index == 7'd127);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e || frame_strobe) check("frame_strobe", frame_strobe, e);
            if (frame_strobe) strobe_seen++;
        end
        if (beat_out) beat_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int got;

        //             manual mthresh flag rate code
        vecs[0] = '{1'b0, 4'd0, 1'b1, 8'd8, 4'd4};
        vecs[1] = '{1'b0, 4'd0, 1'b0, 8'd0, 4'd3};
        vecs[2] = '{1'b0, 4'd0, 1'b0, 8'd0, 4'd2};
        vecs[3] = '{1'b0, 4'd0, 1'b0, 8'd0, 4'd1};
        vecs[4] = '{1'b0, 4'd0, 1'b0, 8'd0, 4'd0};
        vecs[5] = '{1'b0, 4'd0, 1'b0, 8'd0, 4'd0};
        vecs[6] = '{1'b1, 4'd9, 1'b0, 8'd0, 4'd9};
        vecs[7] = '{1'b0, 4'd0, 1'b0, 8'd0, 4'd8};
        vecs[8] = '{1'b0, 4'd0, 1'b1, 8'd8, 4'd8};

        // Reset state
        do_reset();
        check("reset beat_threshold", beat_threshold, 4);
        check("reset beat_out", beat_out, 0);
        check("reset frame_strobe", frame_strobe, 0);
        check("reset holdoff_active", holdoff_active, 0);
        check("reset beat_rate", beat_rate, 0);

        // Enabled with no FFT traffic: nothing moves
        enable = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            if (i % 250 == 249) begin
                check("idle beat_threshold", beat_threshold, 4);
                check("idle beat_out", beat_out, 0);
                check("idle beat_rate", beat_rate, 0);
            end
        end

        // Full index sweep with a single beat pulse at bin 10
        base = strobe_seen;
        for (int i = 0; i < 128; i++) begin
            valid_in     = 1'b1;
            fft_index    = 7'(i);
            beat_flag_in = (i == 10);
            @(negedge clk_100mhz);
            if (i == 9)  check("sweep beat_out before flag", beat_out, 0);
            if (i == 10) check("sweep beat_out latency 1", beat_out, 1);
            if (i == 10) check("sweep holdoff entered", holdoff_active, 1);
            if (i == 11) check("sweep beat_out single pulse", beat_out, 0);
            if (i == 126) check("sweep no early strobe", strobe_seen - base, 0);
        end
        valid_in     = 1'b0;
        beat_flag_in = 1'b0;
        check("sweep one frame_strobe", strobe_seen - base, 1);
        holdoff_release(7, "sweep");

        // Beat coincident with a frame end: fresh load, no decrement
        for (int i = 124; i <= 127; i++) begin
            valid_in     = 1'b1;
            fft_index    = 7'(i);
            beat_flag_in = (i == 127);
            @(negedge clk_100mhz);
        end
        valid_in     = 1'b0;
        beat_flag_in = 1'b0;
        check("coincident beat_out", beat_out, 1);
        holdoff_release(8, "coincident");

        // Drop enable mid-hold-off, then re-enable with the flag held
        beat_flag_in = 1'b1;
        cyc(1);
        beat_flag_in = 1'b0;
        check("pre-disable holdoff", holdoff_active, 1);
        enable = 1'b0;
        cyc(1);
        check("disable clears holdoff", holdoff_active, 0);
        check("disable beat_out", beat_out, 0);
        cyc(3);
        enable       = 1'b1;
        beat_flag_in = 1'b1;
        got = 0;
        for (int k = 0; k < 2 && got == 0; k++) begin
            cyc(1);
            if (beat_out) got = 1;
        end
        beat_flag_in = 1'b0;
        check("re-enable beat within 2 cycles", got, 1);

        // Adaptation windows, one table row per 64-frame window
        do_reset();
        beat_flag_in = vecs[0].flag;
        enable       = 1'b1;
        base         = beat_seen;
        cyc(2);
        for (int r = 0; r < 9; r++) begin
            manual_mode   = vecs[r].manual;
            manual_thresh = vecs[r].mthresh;
            beat_flag_in  = vecs[r].flag;
            if (r > 0) base = beat_seen;
            repeat (64) drive_frame(124);
            check($sformatf("win%0d beat_rate", r), beat_rate, vecs[r].exp_rate);
            check($sformatf("win%0d beat_threshold", r), beat_threshold, vecs[r].exp_code);
            check($sformatf("win%0d beat pulses", r), beat_seen - base, vecs[r].exp_rate);
            if (r == 0) begin
                check("h4 beat_rate", h4_beat_rate, 13);
                check("h4 beat_threshold", h4_threshold, 5);
            end
        end
        beat_flag_in = 1'b0;

        // Manual override latency and hold after release
        manual_mode   = 1'b1;
        manual_thresh = 4'd3;
        cyc(1);
        check("manual thresh 3", beat_threshold, 3);
        manual_thresh = 4'd12;
        cyc(1);
        check("manual thresh 12", beat_threshold, 12);
        manual_mode = 1'b0;
        cyc(2);
        check("manual released holds", beat_threshold, 12);

        // Reset in the middle of a frame and a hold-off
        beat_flag_in = 1'b1;
        for (int i = 124; i <= 126; i++) begin
            valid_in  = 1'b1;
            fft_index = 7'(i);
            rst       = (i == 126);
            @(negedge clk_100mhz);
        end
        rst          = 1'b0;
        valid_in     = 1'b0;
        beat_flag_in = 1'b0;
        check("mid-frame rst beat_threshold", beat_threshold, 4);
        check("mid-frame rst beat_out", beat_out, 0);
        check("mid-frame rst frame_strobe", frame_strobe, 0);
        check("mid-frame rst holdoff_active", holdoff_active, 0);
        check("mid-frame rst beat_rate", beat_rate, 0);
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
